ma_seq: RTL and testbench

//  Sequencer for the moving-average (MA) core in the CMUL -> MA chain. Owns the
//  AXI-Stream handshake on both sides of the MA core: gates the core enable,

---
 rtl/ma_seq.sv | 184 ++++++++++++++++++
 tb/tb_ma_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ma_seq.sv
// Sequencer around the moving-average core: AXI-Stream handshake, core enable/clear,
// window-fill tracking and an output FIFO. Define MA_SEQ_WARMUP_EN to suppress partial-window results.
module ma_seq #(
  parameter int WORD_LENGTH       = 71,
  parameter int MA_SNAPSHOT_COUNT = 4,
  parameter int MA_LAT            = 1,
  parameter int OB_DEPTH          = MA_LAT + 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_LENGTH-1:0] s_tdata,
  input  logic                   s_tvalid,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic [WORD_LENGTH-1:0] m_tdata,
  output logic                   m_tvalid,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic                   ma_en,
  output logic [WORD_LENGTH-1:0] ma_in,
  output logic                   ma_clr,
  input  logic [WORD_LENGTH-1:0] ma_out,
  output logic                   busy
);

  localparam int N   = MA_SNAPSHOT_COUNT;
  localparam int FCW = (N > 2) ? $clog2(N) : 1;
  localparam int OCW = $clog2(OB_DEPTH + 1);
  localparam int ICW = $clog2(MA_LAT + 1);
  localparam int SCW = $clog2(OB_DEPTH + MA_LAT + 1);
  localparam int PW  = (OB_DEPTH > 1) ? $clog2(OB_DEPTH) : 1;

  typedef enum logic [1:0] {
    CLEAR,
    FILL,
    RUN,
    DRAIN
  } state_t;

  state_t state, state_nx;
  logic [FCW-1:0] fill_cnt, fill_cnt_nx;

  logic accept;
  logic keep;
  logic credit_ok;
  logic push, pop;

  logic [MA_LAT-1:0] pipe_vld;
  logic [MA_LAT-1:0] pipe_keep;
  logic [MA_LAT-1:0] pipe_last;
  logic [ICW-1:0]    inflight;

  logic [WORD_LENGTH-1:0] mem [OB_DEPTH];
  logic [OB_DEPTH-1:0]    last_mem;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [OCW-1:0]         occ;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OB_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Input side
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < MA_LAT; i++)
      inflight = inflight + ICW'(pipe_vld[i]);
  end

  // Credit ignores a same-cycle pop so s_tready never depends on m_tready.
  assign credit_ok = (SCW'(occ) + SCW'(inflight)) < SCW'(OB_DEPTH);
  assign s_tready  = ((state == FILL) || (state == RUN)) && credit_ok;
  assign accept    = s_tvalid && s_tready;
  assign ma_en     = accept;
  assign ma_in     = s_tdata;
  assign ma_clr    = (state == CLEAR) && !rst;
  assign busy      = !((state == FILL) && (occ == '0));

`ifdef MA_SEQ_WARMUP_EN
  assign keep = (state != FILL) || s_tlast;
`else
  assign keep = 1'b1;
`endif

  // FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLEAR;
      fill_cnt <= '0;
    end else begin
      state    <= state_nx;
      fill_cnt <= fill_cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    fill_cnt_nx = fill_cnt;
    case (state)
      CLEAR: begin
        fill_cnt_nx = '0;
        state_nx    = FILL;
      end
      FILL: begin
        if (accept) begin
          fill_cnt_nx = fill_cnt + FCW'(1);
          if (s_tlast)
            state_nx = DRAIN;
          else if (fill_cnt == FCW'(N - 2))
            state_nx = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          if (fill_cnt != FCW'(N - 1))
            fill_cnt_nx = fill_cnt + FCW'(1);
          if (s_tlast)
            state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if ((pipe_vld == '0) && (occ == '0))
          state_nx = CLEAR;
      end
      default: state_nx = CLEAR;
    endcase
  end

  // Tag pipeline: aligns {keep,last} with the core result MA_LAT cycles later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld  <= '0;
      pipe_keep <= '0;
      pipe_last <= '0;
    end else begin
      pipe_vld[0]  <= accept;
      pipe_keep[0] <= keep;
      pipe_last[0] <= s_tlast;
      for (int unsigned i = 1; i < MA_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_keep[i] <= pipe_keep[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
    end
  end

  // Output FIFO
  assign push = pipe_vld[MA_LAT-1] && pipe_keep[MA_LAT-1];
  assign pop  = m_tvalid && m_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push)
        wr_ptr <= ptr_inc(wr_ptr);
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + OCW'(1);
        2'b01:   occ <= occ - OCW'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr]      <= ma_out;
      last_mem[wr_ptr] <= pipe_last[MA_LAT-1];
    end
  end

  assign m_tvalid = (occ != '0);
  assign m_tdata  = m_tvalid ? mem[rd_ptr] : '0;
  assign m_tlast  = m_tvalid && last_mem[rd_ptr];

`ifndef SYNTHESIS
  overflow_check: assert property (@(posedge clk) disable iff (rst)
    !(push && (occ == OCW'(OB_DEPTH))));
`endif

endmodule

// File: tb/tb_ma_seq.sv
// Directed bench for ma_seq with a behavioural 4-tap moving-average core (latency 1).
module tb_ma_seq;
  localparam int W        = 71;
  localparam int OB_DEPTH = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] s_tdata;
  logic         s_tvalid, s_tlast, s_tready;
  logic [W-1:0] m_tdata;
  logic         m_tvalid, m_tlast, m_tready;
  logic         ma_en, ma_clr, busy;
  logic [W-1:0] ma_in, ma_out;

  logic tready_drv, rand_mode, rnd_bit;
  assign m_tready = rand_mode ? rnd_bit : tready_drv;

  always #5 clk = ~clk;

  ma_seq #(.WORD_LENGTH(W), .MA_SNAPSHOT_COUNT(4), .MA_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .ma_en(ma_en), .ma_in(ma_in), .ma_clr(ma_clr), .ma_out(ma_out), .busy(busy)
  );

  // Core: average of the 4 most recent samples, zero-filled after a clear
  logic [W-1:0] w0, w1, w2;
  always @(posedge clk) begin
    if (ma_clr) begin
      w0 <= '0; w1 <= '0; w2 <= '0; ma_out <= '0;
    end else if (ma_en) begin
      ma_out <= (ma_in + w0 + w1 + w2) >> 2;
      w2 <= w1; w1 <= w0; w0 <= ma_in;
    end
  end

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  logic [W-1:0] got_d[$];
  logic         got_l[$];
  logic [W-1:0] exp_d[$];
  logic         exp_l[$];
  int           acc_cnt = 0, en_cnt = 0, clr_cnt = 0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data;
  logic         prev_last;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      check("ma_en", W'(ma_en), W'(s_tvalid && s_tready));
      if (ma_en) check("ma_in", ma_in, s_tdata);
      if (s_tvalid && s_tready) acc_cnt++;
      if (ma_en) en_cnt++;
      if (ma_clr) clr_cnt++;
      if (prev_stall) begin
        check("hold_valid", W'(m_tvalid), W'(1));
        check("hold_data", m_tdata, prev_data);
        check("hold_last", W'(m_tlast), W'(prev_last));
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
      if (m_tvalid && m_tready) begin
        got_d.push_back(m_tdata);
        got_l.push_back(m_tlast);
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic l);
    int n = 0;
    s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!s_tready) check("send_ready", W'(s_tready), W'(1));
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int lim);
    int n = 0;
    @(negedge clk);
    while (!s_tready && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(tag, W'(s_tready), W'(1));
    @(posedge clk); #1;
  endtask

  task automatic expect_outputs(input string tag);
    check({tag, "_count"}, W'(got_d.size()), W'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
      check($sformatf("%s_last%0d", tag, i), W'(got_l[i]), W'(exp_l[i]));
    end
  endtask

  task automatic clear_queues();
    got_d.delete(); got_l.delete(); exp_d.delete(); exp_l.delete();
  endtask

  task automatic add_exp(input logic [W-1:0] d, input logic l);
    exp_d.push_back(d); exp_l.push_back(l);
  endtask

  logic [W-1:0] xs [500];
  logic [W-1:0] sum;
  int           e0, a0, c0, n5;

  initial begin
    rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
    tready_drv = 1'b1; rand_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_s_tready", W'(s_tready), W'(0));
    check("rst_m_tvalid", W'(m_tvalid), W'(0));
    check("rst_m_tlast", W'(m_tlast), W'(0));
    check("rst_m_tdata", m_tdata, '0);
    check("rst_ma_en", W'(ma_en), W'(0));
    check("rst_ma_clr", W'(ma_clr), W'(0));
    check("rst_busy", W'(busy), W'(1));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("clr_pulse", W'(ma_clr), W'(1));
    check("clr_busy", W'(busy), W'(1));
    check("clr_ready", W'(s_tready), W'(0));
    @(negedge clk);
    check("fill_clr_low", W'(ma_clr), W'(0));
    check("fill_ready", W'(s_tready), W'(1));
    check("fill_busy", W'(busy), W'(0));
    @(posedge clk); #1;

    // T1: 8 samples of value 8 at full rate
    clear_queues();
    e0 = en_cnt;
    for (int i = 0; i < 8; i++) send(W'(8), 1'b0);
    repeat (10) @(posedge clk); #1;
    check("t1_en", W'(en_cnt - e0), W'(8));
`ifdef MA_SEQ_WARMUP_EN
    for (int i = 0; i < 5; i++) add_exp(W'(8), 1'b0);
`else
    add_exp(W'(2), 1'b0); add_exp(W'(4), 1'b0); add_exp(W'(6), 1'b0);
    for (int i = 0; i < 5; i++) add_exp(W'(8), 1'b0);
`endif
    expect_outputs("t1");

    // T2: downstream stalled, upstream always valid
    clear_queues();
    a0 = acc_cnt;
    tready_drv = 1'b0; s_tdata = W'(40); s_tlast = 1'b0; s_tvalid = 1'b1;
    repeat (20) @(posedge clk); #1;
    check("t2_accepts", W'(acc_cnt - a0), W'(OB_DEPTH));
    check("t2_ready_low", W'(s_tready), W'(0));
    check("t2_valid", W'(m_tvalid), W'(1));
    s_tvalid = 1'b0; tready_drv = 1'b1;
    repeat (10) @(posedge clk); #1;
    add_exp(W'(16), 1'b0); add_exp(W'(24), 1'b0); add_exp(W'(32), 1'b0);
    expect_outputs("t2");

    // T3: 6-sample frame ending in tlast
    clear_queues();
    c0 = clr_cnt;
    for (int i = 1; i <= 6; i++) send(W'(4 * i), i == 6);
    wait_ready("t3_ready_back", 50);
    check("t3_clr", W'(clr_cnt - c0), W'(1));
    check("t3_idle", W'(busy), W'(0));
    add_exp(W'(31), 1'b0); add_exp(W'(23), 1'b0); add_exp(W'(16), 1'b0);
    add_exp(W'(10), 1'b0); add_exp(W'(14), 1'b0); add_exp(W'(18), 1'b1);
    expect_outputs("t3");

    // T4: tlast on the second sample of a fresh window
    clear_queues();
    c0 = clr_cnt;
    send(W'(100), 1'b0);
    send(W'(200), 1'b1);
    wait_ready("t4_ready_back", 50);
    check("t4_clr", W'(clr_cnt - c0), W'(1));
`ifndef MA_SEQ_WARMUP_EN
    add_exp(W'(25), 1'b0);
`endif
    add_exp(W'(75), 1'b1);
    expect_outputs("t4");

    // T5: reset while the FIFO holds two entries
    clear_queues();
    tready_drv = 1'b0;
`ifdef MA_SEQ_WARMUP_EN
    n5 = 5;
`else
    n5 = 2;
`endif
    for (int i = 1; i <= n5; i++) send(W'(i), 1'b0);
    repeat (4) @(negedge clk);
    check("t5_valid_pre", W'(m_tvalid), W'(1));
    check("t5_busy_pre", W'(busy), W'(1));
    #2 rst = 1'b1;
    #1;
    check("t5_valid_rst", W'(m_tvalid), W'(0));
    check("t5_tdata_rst", m_tdata, '0);
    check("t5_ready_rst", W'(s_tready), W'(0));
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0; tready_drv = 1'b1;
    @(negedge clk);
    check("t5_clr", W'(ma_clr), W'(1));
    @(negedge clk);
    check("t5_ready", W'(s_tready), W'(1));
    @(posedge clk); #1;
    repeat (3) @(posedge clk); #1;
    check("t5_dropped", W'(got_d.size()), W'(0));

    // T6: 500 random samples under random back-pressure
    clear_queues();
    for (int i = 0; i < 500; i++) xs[i] = W'($urandom_range(0, 100000));
    for (int i = 0; i < 500; i++) begin
      sum = '0;
      for (int k = 0; k < 4; k++)
        if (i >= k) sum = sum + xs[i-k];
`ifdef MA_SEQ_WARMUP_EN
      if (i >= 3 || i == 499) add_exp(sum >> 2, i == 499);
`else
      add_exp(sum >> 2, i == 499);
`endif
    end
    rand_mode = 1'b1;
    for (int i = 0; i < 500; i++) send(xs[i], i == 499);
    wait_ready("t6_ready_back", 2000);
    rand_mode = 1'b0;
    expect_outputs("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
